// File: rtl/game_round_engine.sv
// Memory-game round engine: while the game FSM sits in LEVEL_INCREMENT, plays an
// LFSR symbol sequence, checks the player's presses and pulses one result.
module game_round_engine #(
  parameter int         MAX_LEVEL      = 8,
  parameter int         SHOW_CYCLES    = 12000000,
  parameter int         GAP_CYCLES     = 3000000,
  parameter int         TIMEOUT_CYCLES = 120000000,
  parameter logic [7:0] SEED           = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] current_state,
  input  logic       switch1,
  input  logic       switch2,
  input  logic       switch3,
  input  logic       switch4,
  output logic       level_complete,
  output logic       game_over_signal,
  output logic       win_signal,
  output logic [3:0] level,
  output logic       show_valid,
  output logic [1:0] show_code,
  output logic       input_phase,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SHOW_ON  = 3'd1,
    S_SHOW_OFF = 3'd2,
    S_INPUT    = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam int CNT_MAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int TOUT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]        MAX_LVL   = 4'(MAX_LEVEL);

  state_t            state_q, state_d;
  logic [7:0]        lfsr_q, lfsr_d;
  logic [3:0]        idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TOUT_W-1:0] tout_q, tout_d;
  logic [3:0]        level_q, level_d;
  logic              lc_q, lc_d, go_q, go_d, win_q, win_d;
  logic [3:0]        sw_prev_q;

  logic [3:0] sw, edges;
  logic       all_high, one_edge, in_level;
  logic [1:0] edge_sym;
  logic [7:0] lfsr_step;

  assign sw        = {switch4, switch3, switch2, switch1};
  assign edges     = sw & ~sw_prev_q;
  assign all_high  = &sw;
  assign one_edge  = (edges != 4'd0) && ((edges & (edges - 4'd1)) == 4'd0);
  assign in_level  = (current_state == 2'b01);
  assign lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_comb begin
    edge_sym = 2'd0;
    case (edges)
      4'b0001: edge_sym = 2'd0;
      4'b0010: edge_sym = 2'd1;
      4'b0100: edge_sym = 2'd2;
      4'b1000: edge_sym = 2'd3;
      default: edge_sym = 2'd0;
    endcase
  end

  // idx counts elements already played/answered; the last element has idx == level
  // because a round is level+1 symbols long.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tout_d  = tout_q;
    level_d = level_q;
    lc_d    = 1'b0;
    go_d    = 1'b0;
    win_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_level) begin
          lfsr_d  = SEED;
          idx_d   = 4'd0;
          cnt_d   = '0;
          state_d = S_SHOW_ON;
        end
      end
      S_SHOW_ON: begin
        if (!in_level) begin
          state_d = S_IDLE;
        end else if (cnt_q == SHOW_LAST) begin
          cnt_d   = '0;
          state_d = S_SHOW_OFF;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SHOW_OFF: begin
        if (!in_level) begin
          state_d = S_IDLE;
        end else if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (idx_q == level_q) begin
            lfsr_d  = SEED;
            idx_d   = 4'd0;
            tout_d  = '0;
            state_d = S_INPUT;
          end else begin
            lfsr_d  = lfsr_step;
            idx_d   = idx_q + 4'd1;
            state_d = S_SHOW_ON;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_INPUT: begin
        // All four switches high is the reset combo: never judged, but the timeout keeps running.
        if (!in_level) begin
          state_d = S_IDLE;
        end else if ((edges != 4'd0) && !all_high) begin
          if (one_edge && (edge_sym == lfsr_q[1:0])) begin
            if (idx_q == level_q) begin
              if (level_q >= MAX_LVL) begin
                win_d   = 1'b1;
                level_d = 4'd1;
              end else begin
                lc_d    = 1'b1;
                level_d = level_q + 4'd1;
              end
              state_d = S_DONE;
            end else begin
              lfsr_d = lfsr_step;
              idx_d  = idx_q + 4'd1;
              tout_d = '0;
            end
          end else begin
            go_d    = 1'b1;
            level_d = 4'd1;
            state_d = S_DONE;
          end
        end else if (tout_q == TOUT_LAST) begin
          go_d    = 1'b1;
          level_d = 4'd1;
          state_d = S_DONE;
        end else begin
          tout_d = tout_q + TOUT_W'(1);
        end
      end
      S_DONE: begin
        if (!in_level) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      lfsr_q    <= SEED;
      idx_q     <= 4'd0;
      cnt_q     <= '0;
      tout_q    <= '0;
      level_q   <= 4'd1;
      lc_q      <= 1'b0;
      go_q      <= 1'b0;
      win_q     <= 1'b0;
      sw_prev_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      tout_q    <= tout_d;
      level_q   <= level_d;
      lc_q      <= lc_d;
      go_q      <= go_d;
      win_q     <= win_d;
      sw_prev_q <= sw;
    end
  end

  // show_code carries a symbol only while show_valid is high; the display cannot stall it.
  assign show_valid       = (state_q == S_SHOW_ON);
  assign show_code        = show_valid ? lfsr_q[1:0] : 2'b00;
  assign input_phase      = (state_q == S_INPUT);
  assign level            = level_q;
  assign level_complete   = lc_q;
  assign game_over_signal = go_q;
  assign win_signal       = win_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_game_round_engine.sv
// Directed bench for game_round_engine: shows, presses, timeouts, aborts and reset,
// with result pulses checked against a queue of expected outcomes.
module tb_game_round_engine;

  localparam int SHOW = 4;
  localparam int GAP  = 2;
  localparam int TOUT = 50;
  localparam int MAXL = 2;

  localparam logic [2:0] R_LC  = 3'b001;
  localparam logic [2:0] R_GO  = 3'b010;
  localparam logic [2:0] R_WIN = 3'b100;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] cur_state;
  logic [3:0] sw;
  logic       level_complete, game_over_signal, win_signal;
  logic [3:0] level;
  logic       show_valid, input_phase;
  logic [1:0] show_code;
  logic [2:0] dbg_state;

  int         n_checks = 0;
  int         n_err = 0;
  logic [2:0] exp_q[$];
  int         seq[3] = '{1, 2, 1};

  always #5 clk = ~clk;

  game_round_engine #(
    .MAX_LEVEL(MAXL), .SHOW_CYCLES(SHOW), .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(TOUT), .SEED(8'hA5)
  ) dut (
    .clk(clk), .reset(rst), .current_state(cur_state),
    .switch1(sw[0]), .switch2(sw[1]), .switch3(sw[2]), .switch4(sw[3]),
    .level_complete(level_complete), .game_over_signal(game_over_signal),
    .win_signal(win_signal), .level(level), .show_valid(show_valid),
    .show_code(show_code), .input_phase(input_phase), .dbg_state(dbg_state)
  );

  function automatic logic [2:0] pulses();
    return {win_signal, game_over_signal, level_complete};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive LEVEL_INCREMENT and follow the whole show phase into INPUT.
  task automatic start_round(input int len);
    cur_state = 2'b01;
    for (int e = 0; e < len; e++) begin
      for (int k = 0; k < SHOW; k++) begin
        @(negedge clk);
        chk("show_valid_on", show_valid, 1);
        chk("show_code", show_code, seq[e]);
      end
      for (int k = 0; k < GAP; k++) begin
        @(negedge clk);
        chk("show_valid_gap", show_valid, 0);
        chk("show_code_gap", show_code, 0);
      end
    end
    @(negedge clk);
    chk("input_phase", input_phase, 1);
  endtask

  task automatic press(input logic [3:0] m);
    sw = m;
    @(negedge clk);
    sw = 4'b0000;
  endtask

  task automatic wait_result(input string tag, input int budget, input int exp_wait);
    int w = 0;
    logic [2:0] got;
    logic [2:0] expv;
    while (pulses() == 3'b000 && w < budget) begin
      @(negedge clk);
      w++;
    end
    got  = pulses();
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b000;
    chk(tag, got, expv);
    chk({tag, "_latency"}, w, exp_wait);
    @(negedge clk);
    chk({tag, "_one_cycle"}, pulses(), 0);
  endtask

  task automatic idle_cs();
    cur_state = 2'b00;
    repeat (3) @(negedge clk);
  endtask

  task automatic pass_level1(input string tag);
    start_round(2);
    press(4'b0010);
    chk({tag, "_first_no_pulse"}, pulses(), 0);
    @(negedge clk);
    exp_q.push_back(R_LC);
    press(4'b0100);
    chk({tag, "_level_with_pulse"}, level, 2);
    wait_result(tag, 2, 0);
  endtask

  initial begin
    rst = 1'b1;
    cur_state = 2'b00;
    sw = 4'b0000;
    repeat (2) @(negedge clk);
    chk("rst_level", level, 1);
    chk("rst_pulses", pulses(), 0);
    chk("rst_show_valid", show_valid, 0);
    chk("rst_show_code", show_code, 0);
    chk("rst_input_phase", input_phase, 0);
    chk("rst_state", dbg_state, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_hold", dbg_state, 0);

    // Level 1 passes: level_complete and level 2; DONE must not restart the round.
    pass_level1("a_level_complete");
    chk("a_level", level, 2);
    for (int k = 0; k < 4; k++) begin
      chk("a_done_no_show", show_valid, 0);
      chk("a_done_no_input", input_phase, 0);
      chk("a_done_state", dbg_state, 4);
      @(negedge clk);
    end
    idle_cs();

    // Abort mid-SHOW_ON: show drops on the next edge, no pulse, level kept.
    cur_state = 2'b01;
    @(negedge clk);
    chk("g_show_valid", show_valid, 1);
    chk("g_show_code", show_code, 1);
    @(negedge clk);
    cur_state = 2'b00;
    @(negedge clk);
    chk("g_abort_show_valid", show_valid, 0);
    chk("g_abort_state", dbg_state, 0);
    chk("g_abort_level", level, 2);
    for (int k = 0; k < 3; k++) begin
      chk("g_abort_no_pulse", pulses(), 0);
      @(negedge clk);
    end

    // Level 2 (last level) passes: win and level back to 1.
    start_round(3);
    press(4'b0010);
    chk("b_press1_no_pulse", pulses(), 0);
    @(negedge clk);
    press(4'b0100);
    chk("b_press2_no_pulse", pulses(), 0);
    @(negedge clk);
    exp_q.push_back(R_WIN);
    press(4'b0010);
    chk("b_level_with_pulse", level, 1);
    wait_result("b_win", 2, 0);
    idle_cs();

    // Wrong first symbol.
    start_round(2);
    exp_q.push_back(R_GO);
    press(4'b1000);
    chk("c_level_with_pulse", level, 1);
    wait_result("c_wrong_symbol", 2, 0);
    idle_cs();

    // No press at all: timeout after TOUT clocks in INPUT.
    start_round(2);
    exp_q.push_back(R_GO);
    wait_result("d_timeout", TOUT + 10, TOUT);
    idle_cs();

    // Two simultaneous edges.
    start_round(2);
    exp_q.push_back(R_GO);
    press(4'b0110);
    wait_result("e_double_edge", 2, 0);
    idle_cs();

    // All-high combo is ignored and does not restart the timeout.
    start_round(2);
    press(4'b0010);
    for (int k = 0; k < TOUT; k++) begin
      chk("f_no_pulse", pulses(), 0);
      if (k == 5) sw = 4'b1111;
      if (k == 9) sw = 4'b0000;
      @(negedge clk);
    end
    exp_q.push_back(R_GO);
    wait_result("f_allhigh_timeout", 3, 0);
    idle_cs();

    // Back to level 2, then async reset in the middle of INPUT.
    pass_level1("h_level_complete");
    chk("h_level", level, 2);
    idle_cs();
    start_round(3);
    press(4'b0010);
    chk("h_press_no_pulse", pulses(), 0);
    #2 rst = 1'b1;
    #1;
    chk("h_rst_pulses", pulses(), 0);
    chk("h_rst_show_valid", show_valid, 0);
    chk("h_rst_show_code", show_code, 0);
    chk("h_rst_input_phase", input_phase, 0);
    chk("h_rst_level", level, 1);
    chk("h_rst_state", dbg_state, 0);
    @(negedge clk);
    rst = 1'b0;
    cur_state = 2'b00;
    @(negedge clk);

    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not complete");
  end

endmodule
